// File: rtl/loader_pkg.sv
// Shared types and helpers for the AXI-Stream to BRAM loader.
//   state_t   : loader FSM state encoding
//   sel_width : width of a target index for a given target count (min 1 bit)
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_TARGETS = 3;

  // SEL_W = max(1, clog2(n))
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_SEL_W = sel_width(DEF_NUM_TARGETS);

endpackage

// File: rtl/target_decoder.sv
// One-hot write-enable decode for the BRAM targets.
//   en     : write strobe
//   sel    : target index
//   onehot : bit sel set when en, all-zero otherwise
module target_decoder #(
  parameter int NUM_TARGETS = 3,
  parameter int SEL_W       = 2
) (
  input  logic                   en,
  input  logic [SEL_W-1:0]       sel,
  output logic [NUM_TARGETS-1:0] onehot
);

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_bit
    assign onehot[i] = en && (sel == SEL_W'(i));
  end

endmodule

// File: rtl/axis_bram_loader.sv
// Loads one AXI-Stream packet into one of NUM_TARGETS BRAMs per start pulse.
// Ports:
//   S_AXIS_*      : stream slave (clock, async active-low reset, data/valid/last/ready)
//   start         : arms one load; target_sel/base_addr/max_words sampled with it
//   err_clr       : clears sticky ovf_err/sel_err (a same-cycle set wins)
//   bram_addr/din : shared registered write port, bram_we one-hot per target
//   busy/done     : load in progress / one-cycle completion pulse
//   word_count    : words written by the last packet
//   ovf_err       : packet exceeded max_words (excess beats drained)
//   sel_err       : start issued with an out-of-range target
module axis_bram_loader
  import loader_pkg::*;
#(
  parameter  int NUM_TARGETS = 3,
  parameter  int ADDR_WIDTH  = 11,
  parameter  int DATA_WIDTH  = 32,
  localparam int SEL_W       = sel_width(NUM_TARGETS)
) (
  input  logic                   S_AXIS_ACLK,
  input  logic                   S_AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  input  logic                   S_AXIS_TLAST,
  output logic                   S_AXIS_TREADY,
  input  logic                   start,
  input  logic [SEL_W-1:0]       target_sel,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    max_words,
  input  logic                   err_clr,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0]  bram_din,
  output logic [NUM_TARGETS-1:0] bram_we,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic                   ovf_err,
  output logic                   sel_err
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CAP_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      tgt;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   cap, cnt, cnt_inc;
  logic                  beat, load_beat, drain_last, full, sel_ok, start_ok, start_bad;
  logic [NUM_TARGETS-1:0] we_dec;

  assign beat       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign load_beat  = beat && (state == ST_LOAD);
  assign drain_last = beat && S_AXIS_TLAST && (state == ST_DRAIN);
  assign cnt_inc    = cnt + CNT_ONE;
  assign full       = (cnt_inc == cap);
  assign sel_ok     = int'(target_sel) < NUM_TARGETS;
  assign start_ok   = start && (state == ST_IDLE) && sel_ok;
  assign start_bad  = start && (state == ST_IDLE) && !sel_ok;

  // FSM: state register
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_LOAD;
      ST_LOAD:  if (beat) begin
                  if (S_AXIS_TLAST) state_nxt = ST_DONE;
                  else if (full)    state_nxt = ST_DRAIN;
                end
      ST_DRAIN: if (drain_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Decoded straight from state so reset clears them at once.
  always_comb begin
    S_AXIS_TREADY = (state == ST_LOAD) || (state == ST_DRAIN);
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
  end

  target_decoder #(
    .NUM_TARGETS(NUM_TARGETS),
    .SEL_W      (SEL_W)
  ) u_dec (
    .en    (load_beat),
    .sel   (tgt),
    .onehot(we_dec)
  );

  // Datapath: latched job, counter, registered write port, status
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      tgt        <= '0;
      base       <= '0;
      cap        <= '0;
      cnt        <= '0;
      bram_addr  <= '0;
      bram_din   <= '0;
      bram_we    <= '0;
      word_count <= '0;
      ovf_err    <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      bram_we <= we_dec;
      if (start_ok) begin
        tgt  <= target_sel;
        base <= base_addr;
        cap  <= (max_words == '0) ? CAP_FULL : max_words;
        cnt  <= '0;
      end
      if (load_beat) begin
        cnt       <= cnt_inc;
        // address wraps naturally at ADDR_WIDTH bits
        bram_addr <= base + cnt[ADDR_WIDTH-1:0];
        bram_din  <= S_AXIS_TDATA;
        if (S_AXIS_TLAST) word_count <= cnt_inc;
      end
      if (drain_last) word_count <= cnt;
      // set beats clear when both happen together
      if (load_beat && !S_AXIS_TLAST && full) ovf_err <= 1'b1;
      else if (err_clr)                       ovf_err <= 1'b0;
      if (start_bad)    sel_err <= 1'b1;
      else if (err_clr) sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_bram_loader.sv
// Directed bench for axis_bram_loader (NUM_TARGETS=3, ADDR_WIDTH=11, DATA_WIDTH=32).
module tb_axis_bram_loader;
  import loader_pkg::*;

  localparam int NT = 3;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SW = sel_width(NT);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic          start, err_clr;
  logic [SW-1:0] target_sel;
  logic [AW-1:0] base_addr;
  logic [AW:0]   max_words;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [NT-1:0] bram_we;
  logic          busy, done, ovf_err, sel_err;
  logic [AW:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_bram_loader #(.NUM_TARGETS(NT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TREADY (tready),
    .start         (start),
    .target_sel    (target_sel),
    .base_addr     (base_addr),
    .max_words     (max_words),
    .err_clr       (err_clr),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count),
    .ovf_err       (ovf_err),
    .sel_err       (sel_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [SW-1:0] s, input logic [AW-1:0] b, input logic [AW:0] m);
    start = 1'b1; target_sel = s; base_addr = b; max_words = m;
    tick();
    start = 1'b0;
  endtask

  logic [AW-1:0] wrap_addr [4];

  initial begin
    rst_n = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    start = 1'b0; err_clr = 1'b0; target_sel = '0; base_addr = '0; max_words = '0;
    wrap_addr[0] = 11'h7FE; wrap_addr[1] = 11'h7FF; wrap_addr[2] = 11'h000; wrap_addr[3] = 11'h001;
    #12;
    chk("rst_tready", 64'(tready), 64'(0));
    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_we",     64'(bram_we), 64'(0));
    chk("rst_wc",     64'(word_count), 64'(0));
    chk("rst_errs",   64'({ovf_err, sel_err}), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // basic 4-beat packet into target 1
    arm(2'd1, 11'h010, 12'd8);
    chk("s1_busy",   64'(busy),   64'(1));
    chk("s1_tready", 64'(tready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tdata = 32'hA000_0000 + i; tvalid = 1'b1; tlast = (i == 3);
      tick();
      chk("s1_we",   64'(bram_we),   64'(3'b010));
      chk("s1_addr", 64'(bram_addr), 64'(11'(16 + i)));
      chk("s1_din",  64'(bram_din),  64'(32'hA000_0000 + i));
    end
    chk("s1_done", 64'(done), 64'(1));
    chk("s1_wc",   64'(word_count), 64'(4));
    tvalid = 1'b0; tlast = 1'b0;
    tick();
    chk("s1_idle_done", 64'(done), 64'(0));
    chk("s1_idle_busy", 64'(busy), 64'(0));
    chk("s1_idle_we",   64'(bram_we), 64'(0));
    chk("s1_errs",      64'({ovf_err, sel_err}), 64'(0));

    // overflow: 5 beats into capacity 3
    arm(2'd0, 11'h100, 12'd3);
    for (int i = 0; i < 5; i++) begin
      tdata = 32'hB000_0000 + i; tvalid = 1'b1; tlast = (i == 4);
      tick();
      if (i < 3) begin
        chk("s2_we",   64'(bram_we),   64'(3'b001));
        chk("s2_addr", 64'(bram_addr), 64'(11'(256 + i)));
      end else begin
        chk("s2_drain_we", 64'(bram_we), 64'(0));
      end
      if (i == 2) chk("s2_ovf", 64'(ovf_err), 64'(1));
      if (i == 3) chk("s2_drain_tready", 64'(tready), 64'(1));
    end
    chk("s2_done", 64'(done), 64'(1));
    chk("s2_wc",   64'(word_count), 64'(3));
    tvalid = 1'b0; tlast = 1'b0;
    tick();
    chk("s2_ovf_sticky", 64'(ovf_err), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("s2_ovf_clr", 64'(ovf_err), 64'(0));

    // address wrap with max_words=0 (full capacity)
    arm(2'd2, 11'h7FE, 12'd0);
    for (int i = 0; i < 4; i++) begin
      tdata = 32'hC000_0000 + i; tvalid = 1'b1; tlast = (i == 3);
      tick();
      chk("s3_we",   64'(bram_we),   64'(3'b100));
      chk("s3_addr", 64'(bram_addr), 64'(wrap_addr[i]));
    end
    chk("s3_wc",  64'(word_count), 64'(4));
    chk("s3_ovf", 64'(ovf_err), 64'(0));
    tvalid = 1'b0; tlast = 1'b0;
    tick();

    // illegal target
    arm(2'd3, 11'h000, 12'd4);
    chk("s4_sel_err", 64'(sel_err), 64'(1));
    chk("s4_busy",    64'(busy),    64'(0));
    tvalid = 1'b1;
    tick();
    chk("s4_tready", 64'(tready), 64'(0));
    chk("s4_we",     64'(bram_we), 64'(0));
    tvalid = 1'b0; err_clr = 1'b1;
    tick();
    chk("s4_clr", 64'(sel_err), 64'(0));
    start = 1'b1; target_sel = 2'd3;
    tick();
    start = 1'b0;
    chk("s4_set_wins", 64'(sel_err), 64'(1));
    tick();
    err_clr = 1'b0;
    chk("s4_clr2", 64'(sel_err), 64'(0));

    // gapped valid, start ignored mid-load
    arm(2'd1, 11'h020, 12'd8);
    tdata = 32'hD000_0000; tvalid = 1'b1; tlast = 1'b0;
    tick();
    chk("s5_we0",   64'(bram_we),   64'(3'b010));
    chk("s5_addr0", 64'(bram_addr), 64'(11'h020));
    tvalid = 1'b0; start = 1'b1; target_sel = 2'd0; base_addr = 11'h300;
    tick();
    start = 1'b0;
    chk("s5_gap_we", 64'(bram_we), 64'(0));
    tdata = 32'hD000_0001; tvalid = 1'b1;
    tick();
    chk("s5_we1",   64'(bram_we),   64'(3'b010));
    chk("s5_addr1", 64'(bram_addr), 64'(11'h021));
    tdata = 32'hD000_0002; tlast = 1'b1;
    tick();
    chk("s5_addr2", 64'(bram_addr), 64'(11'h022));
    chk("s5_din2",  64'(bram_din),  64'(32'hD000_0002));
    chk("s5_done",  64'(done),      64'(1));
    chk("s5_wc",    64'(word_count), 64'(3));
    tvalid = 1'b0; tlast = 1'b0;
    tick();

    // reset mid-packet
    arm(2'd0, 11'h040, 12'd16);
    for (int i = 0; i < 2; i++) begin
      tdata = 32'hE000_0000 + i; tvalid = 1'b1;
      tick();
    end
    chk("s6_pre_we", 64'(bram_we), 64'(3'b001));
    tdata = 32'hE000_0002;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_we",     64'(bram_we),   64'(0));
    chk("s6_rst_addr",   64'(bram_addr), 64'(0));
    chk("s6_rst_din",    64'(bram_din),  64'(0));
    chk("s6_rst_busy",   64'(busy),      64'(0));
    chk("s6_rst_tready", 64'(tready),    64'(0));
    chk("s6_rst_wc",     64'(word_count), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("s6_bp_tready", 64'(tready), 64'(0));
    chk("s6_bp_we",     64'(bram_we), 64'(0));
    tdata = 32'hF000_0000;
    arm(2'd0, 11'h040, 12'd16);
    tick();
    chk("s6_we0",   64'(bram_we),   64'(3'b001));
    chk("s6_addr0", 64'(bram_addr), 64'(11'h040));
    chk("s6_din0",  64'(bram_din),  64'(32'hF000_0000));
    tdata = 32'hF000_0001; tlast = 1'b1;
    tick();
    chk("s6_addr1", 64'(bram_addr), 64'(11'h041));
    chk("s6_done",  64'(done),      64'(1));
    chk("s6_wc",    64'(word_count), 64'(2));
    tvalid = 1'b0; tlast = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_bram_loader.md
AXIS_BRAM_LOADER -- requirements
Module: axis_bram_loader

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, named S_AXIS_ACLK and S_AXIS_ARESETN.
REQ-002 The module SHALL have parameter NUM_TARGETS, default 3, giving the number of BRAM targets (range 2..8).
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 11, giving the BRAM address width.
REQ-004 The module SHALL have parameter DATA_WIDTH, default 32, giving the stream and BRAM data width.
REQ-005 The module SHALL have the following ports:
- S_AXIS_ACLK  in  1  clock
- S_AXIS_ARESETN  in  1  asynchronous active-low reset
- S_AXIS_TDATA  in  DATA_WIDTH  stream data
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TLAST  in  1  last beat of packet
- S_AXIS_TREADY  out  1  beat accept
- start  in  1  single-cycle pulse that arms one packet load
- target_sel  in  SEL_W  target index, sampled on start
- base_addr  in  ADDR_WIDTH  first write address, sampled on start
- max_words  in  ADDR_WIDTH+1  capacity limit, sampled on start
- err_clr  in  1  clears sticky errors
- bram_addr  out  ADDR_WIDTH  shared write address
- bram_din  out  DATA_WIDTH  shared write data
- bram_we  out  NUM_TARGETS  one-hot write enable
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- word_count  out  ADDR_WIDTH+1  words written in the last packet
- ovf_err  out  1  sticky overflow error
- sel_err  out  1  sticky illegal-target error

Function
REQ-006 The module SHALL implement an FSM with states IDLE, LOAD, DRAIN and DONE.
REQ-007 S_AXIS_TREADY SHALL be 1 only in LOAD and DRAIN; a beat is TVALID&TREADY.
REQ-008 In IDLE, a start with target_sel < NUM_TARGETS SHALL latch target_sel, base_addr and max_words, clear the counter, and go to LOAD next cycle.
REQ-009 A start with target_sel >= NUM_TARGETS SHALL set sel_err and remain in IDLE.
REQ-010 A start outside IDLE SHALL be ignored.
REQ-011 max_words = 0 SHALL be treated as 2^ADDR_WIDTH.
REQ-012 Each LOAD beat SHALL write TDATA to base+count, modulo 2^ADDR_WIDTH (address wraps), and increment count.
REQ-013 bram_addr, bram_din and bram_we SHALL be registered, appearing the cycle after the beat; bram_we SHALL be all-zero otherwise.
REQ-014 A LOAD beat with TLAST SHALL go to DONE.
REQ-015 A LOAD beat without TLAST that makes count equal max_words SHALL set ovf_err and go to DRAIN.
REQ-016 A LOAD beat with TLAST on the capacity word SHALL go to DONE without an error.
REQ-017 DRAIN SHALL accept and discard beats (no bram_we) until a TLAST beat, then go to DONE.
REQ-018 DONE SHALL last one cycle, with done=1 and word_count updated, then go to IDLE; done coincides with the final bram_we.
REQ-019 busy SHALL be 1 in LOAD, DRAIN and DONE.
REQ-020 err_clr SHALL clear both sticky errors; a set event in the same cycle SHALL win.

Reset
REQ-021 Asserting reset SHALL immediately force IDLE, TREADY=0, bram_we=0, done=0, busy=0, word_count=0, ovf_err=0, sel_err=0, bram_addr=0 and bram_din=0.
REQ-022 Reset mid-packet SHALL abandon the packet; remaining beats SHALL be back-pressured until the next start.

Structure
REQ-023 The state enumeration and SEL_W = max(1, clog2(NUM_TARGETS)) SHALL live in the shared package loader_pkg.
REQ-024 The one-hot write-enable decode SHALL be the sub-module target_decoder (parameter NUM_TARGETS).

Verification
REQ-025 The bench SHALL cover each of the following directed scenarios:
- start sel=1, base=0x010, max=8; 4 beats (TLAST on the 4th) -> bram_we=0b010 at addresses 0x010..0x013; done with word_count=4; no errors.
- sel=0, max=3; 5-beat packet -> 3 writes; ovf_err=1; 2 beats drained with no we; done with word_count=3.
- base=0x7FE, ADDR_WIDTH=11, 4 beats -> writes to 0x7FE, 0x7FF, 0x000, 0x001.
- start sel=3 with NUM_TARGETS=3 -> sel_err=1, TREADY stays 0; err_clr -> sel_err=0.
- TVALID toggling 1,0,1,1 with TLAST on the last beat -> exactly 3 writes; start mid-LOAD ignored.
- Reset asserted after 2 of 6 beats -> all outputs zero at once; a new start loads cleanly from base.
